// File: rtl/y_pc_ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle PC/control sequencer.
//   - RV32 opcode values recognised by the decoder
//   - ALU operation codes driven on op
//   - FSM state encoding (plain constants so the encoding stays fixed)
//   - instruction class enum used between y_decode and y_pc_ctrl
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4
  } ins_class_t;

endpackage

// File: rtl/y_pc_ctrl_if.sv
// y_pc_ctrl_if: bundle between the control sequencer and the datapath
// (yIF/yID/yEX/data memory).
//   master : the sequencer -- receives start/ins/imm/zero/mem_ready,
//            drives pc, datapath controls, op, halted, illegal, retired.
//   slave  : the datapath side, directions reversed.
interface y_pc_ctrl_if;
  logic        start;
  logic [31:0] ins;
  logic [31:0] imm;
  logic        zero;
  logic        mem_ready;
  logic [31:0] pc;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;
  logic [2:0]  op;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  start, ins, imm, zero, mem_ready,
    output pc, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op,
           halted, illegal, retired
  );

  modport slave (
    output start, ins, imm, zero, mem_ready,
    input  pc, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op,
           halted, illegal, retired
  );
endinterface

// File: rtl/y_pc_ctrl_decode.sv
// y_decode: purely combinational instruction decoder.
//   i_ir        : latched instruction word
//   o_alu_src   : 1 selects immediate as ALU operand B
//   o_mem2reg   : 1 selects memory data for register write-back
//   o_op        : ALU operation code
//   o_cls       : instruction class steering the FSM
//   o_illegal   : opcode or funct3/funct7 combination not supported
module y_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic        o_alu_src,
  output logic        o_mem2reg,
  output logic [2:0]  o_op,
  output ins_class_t  o_cls,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_fields;

  assign w_opcode = i_ir[6:0];
  assign w_funct3 = i_ir[14:12];
  assign w_funct7 = i_ir[31:25];
  // Register/immediate fields are consumed by the datapath, not here.
  assign w_unused_fields = ^{i_ir[24:15], i_ir[11:7]};

  always_comb begin
    o_alu_src = 1'b0;
    o_mem2reg = 1'b0;
    o_op      = ALU_ADD;
    o_cls     = CLS_ALU;
    o_illegal = 1'b0;
    case (w_opcode)
      OPC_R: begin
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: o_op = ALU_ADD;
          {7'h20, 3'b000}: o_op = ALU_SUB;
          {7'h00, 3'b111}: o_op = ALU_AND;
          {7'h00, 3'b110}: o_op = ALU_OR;
          {7'h00, 3'b010}: o_op = ALU_SLT;
          default:         o_illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        o_alu_src = 1'b1;
        if (w_funct3 != 3'b000) o_illegal = 1'b1;
      end
      OPC_LOAD: begin
        o_alu_src = 1'b1;
        o_mem2reg = 1'b1;
        o_cls     = CLS_LOAD;
      end
      OPC_STORE: begin
        o_alu_src = 1'b1;
        o_cls     = CLS_STORE;
      end
      OPC_BRANCH: begin
        o_op  = ALU_SUB;
        o_cls = CLS_BRANCH;
      end
      OPC_JAL: o_cls = CLS_JAL;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/y_pc_ctrl.sv
// y_pc_ctrl: multi-cycle control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : y_pc_ctrl_if.master -- start/ins/imm/zero/mem_ready in;
//                pc, RegWrite/ALUSrc/MemRead/MemWrite/Mem2Reg, op,
//                halted, illegal, retired out
// Holds the FSM, pc, instruction register and retired-instruction counter;
// decode is delegated to y_decode.
module y_pc_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] ENTRY_PC = 32'h28
) (
  input  logic        clk,
  input  logic        reset,
  y_pc_ctrl_if.master bus
);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [15:0] r_retired;
  logic        r_illegal;

  logic [2:0]  w_state_next;
  logic        w_final;
  logic        w_take;
  logic        w_active;
  logic [31:0] w_pc_next;
  logic        w_dec_alu_src;
  logic        w_dec_mem2reg;
  logic [2:0]  w_dec_op;
  ins_class_t  w_cls;
  logic        w_dec_illegal;

  y_decode u_decode (
    .i_ir      (r_ir),
    .o_alu_src (w_dec_alu_src),
    .o_mem2reg (w_dec_mem2reg),
    .o_op      (w_dec_op),
    .o_cls     (w_cls),
    .o_illegal (w_dec_illegal)
  );

  // w_final marks the last cycle of an instruction: pc and retired update
  // on that edge and the FSM returns to FETCH.
  always_comb begin
    w_state_next = r_state;
    w_final      = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = w_dec_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (w_cls)
          CLS_LOAD, CLS_STORE:  w_state_next = S_MEM;
          CLS_BRANCH, CLS_JAL:  w_final = 1'b1;
          default:              w_state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (w_cls == CLS_LOAD) w_state_next = S_WB;
          else                   w_final = 1'b1;
        end
      end
      S_WB:   w_final = 1'b1;
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
    if (w_final) w_state_next = S_FETCH;
  end

  // Branch/jal finish in EXEC, so zero is sampled on the EXEC edge.
  assign w_take    = (w_cls == CLS_JAL) || ((w_cls == CLS_BRANCH) && bus.zero);
  assign w_pc_next = r_pc + (w_take ? bus.imm : 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= ENTRY_PC;
      r_ir      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_FETCH) r_ir <= bus.ins;
      if ((r_state == S_DECODE) && w_dec_illegal) r_illegal <= 1'b1;
      if (w_final) begin
        r_pc <= w_pc_next;
        if (r_retired != '1) r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Decoded controls are exposed only while an instruction is in flight,
  // so they stay constant from DECODE to the final state and read as
  // reset values in IDLE/FETCH/HALT.
  assign w_active = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                    (r_state == S_MEM)    || (r_state == S_WB);

  assign bus.pc       = r_pc;
  assign bus.ALUSrc   = w_active & w_dec_alu_src;
  assign bus.Mem2Reg  = w_active & w_dec_mem2reg;
  assign bus.op       = w_active ? w_dec_op : ALU_ADD;
  assign bus.RegWrite = (r_state == S_WB);
  assign bus.MemRead  = (r_state == S_MEM) && (w_cls == CLS_LOAD);
  assign bus.MemWrite = (r_state == S_MEM) && (w_cls == CLS_STORE);
  assign bus.halted   = (r_state == S_HALT);
  assign bus.illegal  = r_illegal;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_y_pc_ctrl.sv
// Directed testbench for y_pc_ctrl: a table of instruction vectors run
// back-to-back, plus hand-written sequences for illegal decode and
// reset during a store's MEM phase.
module tb_y_pc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  y_pc_ctrl_if bus ();

  y_pc_ctrl #(.ENTRY_PC(32'h28)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic        zero;
    int unsigned wait_cyc;
    int unsigned ncyc;
    logic [31:0] exp_pc;
    int unsigned exp_rw;
    int unsigned exp_mr;
    int unsigned exp_mw;
    logic [2:0]  exp_op;
    logic        exp_src;
    logic        exp_m2r;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t        vecs [14];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] cur_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cur_pc = 32'h28;
  endtask

  // Entered at the start of FETCH (#1 after the edge); leaves at the start
  // of the next FETCH.
  task automatic run_vec(input int idx);
    vec_t        v;
    int unsigned rw, mr, mw, memk, pc_bad, ctl_bad;
    v = vecs[idx];
    rw = 0; mr = 0; mw = 0; memk = 0; pc_bad = 0; ctl_bad = 0;
    for (int unsigned i = 0; i < v.ncyc; i++) begin
      bus.ins  = v.ins;
      bus.imm  = v.imm;
      bus.zero = (i == 2) ? v.zero : ~v.zero;
      if (bus.pc !== cur_pc) pc_bad++;
      if (bus.RegWrite) rw++;
      if (bus.MemRead)  mr++;
      if (bus.MemWrite) mw++;
      if (i >= 1 && (bus.op !== v.exp_op || bus.ALUSrc !== v.exp_src ||
                     bus.Mem2Reg !== v.exp_m2r)) ctl_bad++;
      if (bus.MemRead || bus.MemWrite) begin
        memk++;
        bus.mem_ready = (memk > v.wait_cyc);
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    check($sformatf("v%0d pc_after", idx), bus.pc, v.exp_pc);
    check($sformatf("v%0d retired", idx), {16'h0, bus.retired}, {16'h0, v.exp_ret});
    check($sformatf("v%0d pc_held", idx), pc_bad, 0);
    check($sformatf("v%0d ctl_stable", idx), ctl_bad, 0);
    check($sformatf("v%0d regwrite_cycles", idx), rw, v.exp_rw);
    check($sformatf("v%0d memread_cycles", idx), mr, v.exp_mr);
    check($sformatf("v%0d memwrite_cycles", idx), mw, v.exp_mw);
    cur_pc = v.exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bad_ins [2];
    int unsigned cnt_rw, cnt_mw;

    //           ins           imm           z  w  n  exp_pc        rw mr mw op      src  m2r ret
    vecs[0]  = '{32'h00000033, 32'h0,        0, 0, 4, 32'h0000002C, 1, 0, 0, 3'b010, 0, 0, 16'd1};
    vecs[1]  = '{32'h40000033, 32'h0,        0, 0, 4, 32'h00000030, 1, 0, 0, 3'b110, 0, 0, 16'd2};
    vecs[2]  = '{32'h00000063, 32'hFFFFFFF8, 1, 0, 3, 32'h00000028, 0, 0, 0, 3'b110, 0, 0, 16'd3};
    vecs[3]  = '{32'h00007033, 32'h0,        0, 0, 4, 32'h0000002C, 1, 0, 0, 3'b000, 0, 0, 16'd4};
    vecs[4]  = '{32'h00006033, 32'h0,        0, 0, 4, 32'h00000030, 1, 0, 0, 3'b001, 0, 0, 16'd5};
    vecs[5]  = '{32'h00000063, 32'hFFFFFFF8, 0, 0, 3, 32'h00000034, 0, 0, 0, 3'b110, 0, 0, 16'd6};
    vecs[6]  = '{32'h00000003, 32'h0,        0, 3, 8, 32'h00000038, 1, 4, 0, 3'b010, 1, 1, 16'd7};
    vecs[7]  = '{32'h00000023, 32'h0,        0, 0, 4, 32'h0000003C, 0, 0, 1, 3'b010, 1, 0, 16'd8};
    vecs[8]  = '{32'h00000013, 32'h0,        0, 0, 4, 32'h00000040, 1, 0, 0, 3'b010, 1, 0, 16'd9};
    vecs[9]  = '{32'h00002033, 32'h0,        0, 0, 4, 32'h00000044, 1, 0, 0, 3'b111, 0, 0, 16'd10};
    vecs[10] = '{32'h00000023, 32'h0,        0, 2, 6, 32'h00000048, 0, 0, 3, 3'b010, 1, 0, 16'd11};
    vecs[11] = '{32'h0000006F, 32'hFFFFFFB0, 0, 0, 3, 32'hFFFFFFF8, 0, 0, 0, 3'b010, 0, 0, 16'd12};
    vecs[12] = '{32'h0000006F, 32'h00000010, 0, 0, 3, 32'h00000008, 0, 0, 0, 3'b010, 0, 0, 16'd13};
    vecs[13] = '{32'h0000006F, 32'h00000038, 0, 0, 3, 32'h00000040, 0, 0, 0, 3'b010, 0, 0, 16'd14};

    bus.start = 1'b0; bus.ins = 32'h00000033; bus.imm = '0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    cur_pc = 32'h28;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst pc", bus.pc, 32'h28);
    check("rst retired", {16'h0, bus.retired}, 32'h0);
    check("rst ctl", {24'h0, bus.halted, bus.illegal, bus.RegWrite, bus.MemRead,
                      bus.MemWrite, bus.ALUSrc, bus.Mem2Reg, 1'b0}, 32'h0);
    check("rst op", {29'h0, bus.op}, 32'h2);
    @(negedge clk);
    reset = 1'b0;

    // IDLE must not advance without start.
    repeat (6) @(posedge clk);
    #1;
    check("idle pc", bus.pc, 32'h28);
    check("idle retired", {16'h0, bus.retired}, 32'h0);

    pulse_start();
    for (int i = 0; i < 14; i++) run_vec(i);

    // Unknown opcode at 0x40: FETCH, DECODE, then HALT with pc held.
    bus.ins = 32'h0000007F;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("ill halted", {31'h0, bus.halted}, 32'h1);
    check("ill illegal", {31'h0, bus.illegal}, 32'h1);
    check("ill pc", bus.pc, 32'h40);
    pulse_start();
    bus.ins = 32'h00000033;
    repeat (6) @(posedge clk);
    #1;
    check("halt sticky", {31'h0, bus.halted}, 32'h1);
    check("halt pc", bus.pc, 32'h40);
    check("halt retired", {16'h0, bus.retired}, 32'd14);
    check("halt regwrite", {31'h0, bus.RegWrite}, 32'h0);

    // Unsupported funct3 on R-type and I-type.
    bad_ins[0] = 32'h00001033;
    bad_ins[1] = 32'h00001013;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      #1;
      check($sformatf("f%0d illegal_clear", k), {30'h0, bus.halted, bus.illegal}, 32'h0);
      bus.ins = bad_ins[k];
      pulse_start();
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("f%0d halted_illegal", k), {30'h0, bus.halted, bus.illegal}, 32'h3);
      check($sformatf("f%0d pc", k), bus.pc, 32'h28);
    end

    // Reset during MEM of a store.
    do_reset();
    pulse_start();
    run_vec(0);
    bus.ins = 32'h00000023;
    bus.mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("st in_mem memwrite", {31'h0, bus.MemWrite}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("st rst memwrite", {31'h0, bus.MemWrite}, 32'h0);
    check("st rst pc", bus.pc, 32'h28);
    check("st rst retired", {16'h0, bus.retired}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    cnt_rw = 0; cnt_mw = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.RegWrite) cnt_rw++;
      if (bus.MemWrite) cnt_mw++;
    end
    check("st post writes", cnt_rw + cnt_mw, 0);
    check("st post pc", bus.pc, 32'h28);
    check("st post retired", {16'h0, bus.retired}, 32'h0);
    bus.mem_ready = 1'b0;
    cur_pc = 32'h28;
    pulse_start();
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/y_pc_ctrl.md
Y_PC_CTRL -- requirements
Module: y_pc_ctrl

Interface
REQ-001 Parameter ENTRY_PC, default 32'h28, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 start  in  1  one-cycle pulse; begins execution from IDLE.
REQ-005 ins  in  32  instruction word from yIF at current pc.
REQ-006 imm  in  32  sign-extended immediate from yID.
REQ-007 zero  in  1  ALU zero flag from yEX.
REQ-008 mem_ready  in  1  data-memory completion for load/store.
REQ-009 pc  out  32  program counter driven to yIF.
REQ-010 RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1 each  datapath controls.
REQ-011 op  out  3  ALU operation code.
REQ-012 halted  out  1  high in HALT state; illegal  out  1  high when halt was caused by an unknown opcode.
REQ-013 retired  out  16  count of completed instructions.

Function
REQ-014 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 IDLE->FETCH on start; start in any other state is ignored.
REQ-016 FETCH: pc stable for one cycle; ins latched into an internal ir at the end of FETCH; ->DECODE.
REQ-017 DECODE: opcode ir[6:0] decoded; unknown opcode ->HALT with illegal=1 and pc held at the offending address; otherwise ->EXEC.
REQ-018 Decode table: 0x33 R: ALUSrc=0, RegWrite in WB, op from funct3/funct7 (add 010, sub 110, and 000, or 001, slt 111); 0x13 I-ALU: ALUSrc=1, op from funct3 (addi 010); 0x03 load: ALUSrc=1, op=010, MemRead in MEM, Mem2Reg=1, RegWrite in WB; 0x23 store: ALUSrc=1, op=010, MemWrite in MEM; 0x63 branch (beq): ALUSrc=0, op=110; 0x6F jal: no register or memory write.
REQ-019 Unsupported funct3/funct7 for 0x33/0x13 treated as illegal.
REQ-020 ALUSrc, op and Mem2Reg held stable from DECODE through the instruction's final state; RegWrite asserted only in WB, MemRead/MemWrite only in MEM.
REQ-021 EXEC successor: load/store ->MEM; R/I-ALU ->WB; branch/jal final state.
REQ-022 MEM holds while mem_ready=0; on mem_ready=1 load ->WB, store final state.
REQ-023 Latency from FETCH entry: R/I-ALU 4 cycles, load 5 + wait cycles, store 4 + wait cycles, branch/jal 3 cycles.
REQ-024 At end of the final state: pc <= pc+imm if jal, or if beq with zero sampled in EXEC =1; otherwise pc <= pc+4; retired increments; ->FETCH.
REQ-025 pc arithmetic is 32-bit modulo (wrap, no trap); imm used unmodified.
REQ-026 retired saturates at 16'hFFFF.
REQ-027 HALT is left only by reset.

Reset
REQ-028 On reset: state=IDLE, pc=ENTRY_PC, ir=0, retired=0, halted=0, illegal=0, all control outputs 0, op=3'b010.
REQ-029 Reset asserted mid-instruction aborts it with no further RegWrite/MemWrite pulse and no pc update.

Structure
REQ-030 Shared package ctrl_pkg holds opcode constants, ALU op codes and state encoding.
REQ-031 Combinational decode in sub-module y_decode (ir -> controls, op, class, illegal); y_pc_ctrl holds FSM, pc, ir, counter.

Verification
REQ-032 Reset then start, ins=add (0x33, f3=0, f7=0) -> FETCH,DECODE,EXEC,WB; RegWrite=1 only in WB; op=010; pc 0x28->0x2C; retired=1.
REQ-033 Load 0x03 with mem_ready low 3 cycles -> MemRead held 4 cycles, Mem2Reg=1, single RegWrite pulse, 8 cycles total, pc+4.
REQ-034 beq imm=-8 at pc=0x30, zero=1 -> pc=0x28 after 3 cycles; zero=0 -> pc=0x34.
REQ-035 jal imm=0x10 at pc=0xFFFFFFF8 -> pc=0x00000008 (wrap); no RegWrite/MemWrite.
REQ-036 ins opcode 0x7F at pc=0x40 -> HALT, halted=1, illegal=1, pc=0x40; further start ignored.
REQ-037 reset asserted during MEM of store -> no MemWrite after reset, pc=0x28, state IDLE, retired=0.
